// File: rtl/hpdcache_victim_alloc.sv
// hpdcache_victim_alloc: picks a refill way through the PLRU and blocks a second refill to a set that already has one in flight
module hpdcache_victim_alloc #(
   parameter int unsigned SETS     = 64,
   parameter int unsigned WAYS     = 4,
   parameter int unsigned INFLIGHT = 4,
   localparam int unsigned SW      = $clog2(SETS),
   localparam int unsigned IDW     = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1
)(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [SW-1:0]   req_set_i,
   output logic            dir_rd_o,
   output logic [SW-1:0]   dir_rd_set_o,
   input  logic [WAYS-1:0] dir_valid_i,
   output logic            plru_repl_o,
   output logic [SW-1:0]   plru_repl_set_o,
   output logic [WAYS-1:0] plru_dir_valid_o,
   output logic            plru_updt_plru_o,
   input  logic [WAYS-1:0] plru_victim_way_i,
   output logic            alloc_valid_o,
   input  logic            alloc_ready_i,
   output logic [SW-1:0]   alloc_set_o,
   output logic [WAYS-1:0] alloc_way_o,
   output logic            alloc_evict_o,
   output logic [IDW-1:0]  alloc_id_o,
   input  logic            refill_done_i,
   input  logic [IDW-1:0]  refill_done_id_i
);
   typedef enum logic [1:0] {IDLE, DIR, SEL, RESP} state_t;
   state_t                r_state;
   logic [SW-1:0]         r_set;
   logic [IDW-1:0]        r_id;
   logic [WAYS-1:0]       r_way;
   logic                  r_evict;
   logic                  r_alloc_valid;
   logic [INFLIGHT-1:0]   r_tv;
   logic [SW-1:0]         r_ts [INFLIGHT];
   logic                  w_conflict;
   logic                  w_free_ok;
   logic [IDW-1:0]        w_free_id;
   logic                  w_req_hs;
   logic                  w_repl;
   // scan the in-flight table: set conflict and lowest free tag (table state before any same-cycle clear)
   always_comb begin
      w_conflict = 1'b0;
      w_free_ok  = 1'b0;
      w_free_id  = '0;
      for (int i = INFLIGHT - 1; i >= 0; i--) begin
         if (r_tv[i] && r_ts[i] == req_set_i) w_conflict = 1'b1;
         if (!r_tv[i]) begin
            w_free_ok = 1'b1;
            w_free_id = IDW'(i);
         end
      end
   end
   assign req_ready_o      = rst_ni && r_state == IDLE && !w_conflict && w_free_ok;
   assign w_req_hs         = req_valid_i && req_ready_o;
   assign w_repl           = r_state == DIR;
   assign dir_rd_o         = w_req_hs;
   assign dir_rd_set_o     = w_req_hs ? req_set_i : '0;
   assign plru_repl_o      = w_repl;
   assign plru_repl_set_o  = w_repl ? r_set : '0;
   assign plru_dir_valid_o = w_repl ? dir_valid_i : '0;
   assign plru_updt_plru_o = 1'b1;
   assign alloc_valid_o    = r_alloc_valid;
   assign alloc_set_o      = r_set;
   assign alloc_way_o      = r_way;
   assign alloc_evict_o    = r_evict;
   assign alloc_id_o       = r_id;
   // in-flight table: a refill completion frees its tag, the DIR mark is applied last so it wins a same-tag collision
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tv <= '0;
         r_ts <= '{default: '0};
      end else begin
         if (refill_done_i && 32'(refill_done_id_i) < INFLIGHT) r_tv[refill_done_id_i] <= 1'b0;
         if (w_repl) begin
            r_tv[r_id] <= 1'b1;
            r_ts[r_id] <= r_set;
         end
      end
   end
   // allocation sequence: accept, replace through the PLRU, register, hand the result to the refill path
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= IDLE;
         r_set         <= '0;
         r_id          <= '0;
         r_way         <= '0;
         r_evict       <= 1'b0;
         r_alloc_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_req_hs) begin
               r_set   <= req_set_i;
               r_id    <= w_free_id;
               r_state <= DIR;
            end
            DIR: begin
               r_way   <= plru_victim_way_i;
               r_evict <= |(plru_victim_way_i & dir_valid_i);
               r_state <= SEL;
            end
            SEL: begin
               r_alloc_valid <= 1'b1;
               r_state       <= RESP;
            end
            RESP: if (alloc_ready_i) begin
               r_alloc_valid <= 1'b0;
               r_state       <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
